div_result_bcd: RTL and testbench

Downstream result stage for the 16-bit integer divider: it detects completion of a division, captures the quotient and remainder, and converts both to packed BCD with a sequential shift-and-add-3 (double-dabble) engine. It presents the decimal result on a valid/ready interface for display or reporting logic. The divider's `done` is a level that stays high until the next `start`, so this block triggers on its rising edge only.

---
 rtl/div_result_bcd.sv | 139 +++++++++++++
 tb/tb_div_result_bcd.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_bcd.sv
// Divider result stage: captures quotient/remainder on a done rise and
// converts both to packed BCD with a sequential double-dabble engine.
module div_result_bcd #(
    parameter int W = 16,
    parameter int D = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           div_done,
    input  logic [W-1:0]   quotient,
    input  logic [W-1:0]   remainder,
    input  logic           out_ready,
    input  logic           overrun_clr,
    output logic           out_valid,
    output logic [4*D-1:0] q_bcd,
    output logic [4*D-1:0] r_bcd,
    output logic           busy,
    output logic           overrun
);

    localparam int BW = 4 * D;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        VALID
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          done_q;
    logic          rise;
    logic          drop;
    logic          last_step;
    logic [W-1:0]  q_bin;
    logic [W-1:0]  r_bin;
    logic [BW-1:0] q_acc;
    logic [BW-1:0] r_acc;
    logic [BW-1:0] q_adj;
    logic [BW-1:0] r_adj;
    logic [BW-1:0] q_acc_nx;
    logic [BW-1:0] r_acc_nx;
    logic [4:0]    cnt;

    // Add 3 to every digit >= 5; the result stays within 4 bits.
    function automatic logic [BW-1:0] adjust(input logic [BW-1:0] b);
        logic [BW-1:0] a;
        a = b;
        for (int i = 0; i < D; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                a[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return a;
    endfunction

    assign rise      = div_done & ~done_q;
    assign drop      = rise & (state != IDLE);
    assign last_step = (cnt == 5'(W - 1));

    assign q_adj    = adjust(q_acc);
    assign r_adj    = adjust(r_acc);
    assign q_acc_nx = {q_adj[BW-2:0], q_bin[W-1]};
    assign r_acc_nx = {r_adj[BW-2:0], r_bin[W-1]};

    assign out_valid = (state == VALID);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = CONVERT;
                end
            end
            CONVERT: begin
                if (last_step) begin
                    state_nx = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            overrun <= 1'b0;
            q_bin   <= '0;
            r_bin   <= '0;
            q_acc   <= '0;
            r_acc   <= '0;
            cnt     <= '0;
            q_bcd   <= '0;
            r_bcd   <= '0;
        end else begin
            done_q <= div_done;
            // A dropped rise outranks a simultaneous clear.
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (state == IDLE && rise) begin
                q_bin <= quotient;
                r_bin <= remainder;
                q_acc <= '0;
                r_acc <= '0;
                cnt   <= '0;
            end
            if (state == CONVERT) begin
                q_bin <= q_bin << 1;
                r_bin <= r_bin << 1;
                q_acc <= q_acc_nx;
                r_acc <= r_acc_nx;
                cnt   <= cnt + 5'd1;
                if (last_step) begin
                    q_bcd <= q_acc_nx;
                    r_bcd <= r_acc_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: scoreboard of expected BCD pairs
// popped at each handshake, plus latency, backpressure and overrun checks.
module tb_div_result_bcd;

    logic        clk;
    logic        rst;
    logic        div_done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        out_ready;
    logic        overrun_clr;
    logic        out_valid;
    logic [19:0] q_bcd;
    logic [19:0] r_bcd;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;
    int n_hs  = 0;
    logic [39:0] sb[$];

    div_result_bcd #(.W(16), .D(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_done   (div_done),
        .quotient   (quotient),
        .remainder  (remainder),
        .out_ready  (out_ready),
        .overrun_clr(overrun_clr),
        .out_valid  (out_valid),
        .q_bcd      (q_bcd),
        .r_bcd      (r_bcd),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] b;
        int t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [39:0] e;
            n_hs++;
            if (sb.size() == 0) begin
                chk("sb_depth", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("sb_q", 32'(q_bcd), 32'(e[39:20]));
                chk("sb_r", 32'(r_bcd), 32'(e[19:0]));
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int q, input int r);
        quotient  = 16'(q);
        remainder = 16'(r);
        div_done  = 1'b1;
        sb.push_back({to_bcd(q), to_bcd(r)});
    endtask

    task automatic wait_valid(input bit drop_done, output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            if (drop_done && n == 1) begin
                #1 div_done = 1'b0;
            end
            @(negedge clk);
            if (n == 1) chk("busy_rise", 32'(busy), 32'd1);
            if (out_valid) break;
        end
        if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int n;
        int hs0;
        rst         = 1'b1;
        div_done    = 1'b0;
        quotient    = '0;
        remainder   = '0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd", 32'({q_bcd, r_bcd} != 0), 32'd0);
        drive_edge();
        rst = 1'b0;

        // basic conversion and latency
        drive_edge();
        start(1234, 5);
        wait_valid(1'b1, n);
        chk("latency", 32'(n), 32'd17);
        chk("basic_q", 32'(q_bcd), 32'h01234);
        chk("basic_r", 32'(r_bcd), 32'h00005);
        @(negedge clk);
        chk("pulse_valid", 32'(out_valid), 32'd0);
        chk("pulse_busy", 32'(busy), 32'd0);

        // extremes
        drive_edge();
        start(65535, 0);
        wait_valid(1'b1, n);
        chk("max_q", 32'(q_bcd), 32'h65535);
        chk("max_r", 32'(r_bcd), 32'h00000);
        drive_edge();
        start(0, 40000);
        wait_valid(1'b1, n);
        chk("zero_q", 32'(q_bcd), 32'h00000);
        chk("big_r", 32'(r_bcd), 32'h40000);

        // backpressure
        drive_edge();
        out_ready = 1'b0;
        start(4321, 99);
        wait_valid(1'b1, n);
        for (int i = 0; i < 10; i++) begin
            drive_edge();
            if (i == 9) out_ready = 1'b1;
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_q", 32'(q_bcd), 32'h04321);
            chk("bp_r", 32'(r_bcd), 32'h00099);
        end
        @(negedge clk);
        chk("bp_after", 32'(out_valid), 32'd0);

        // held level gives one conversion
        drive_edge();
        hs0 = n_hs;
        start(7, 3);
        wait_valid(1'b0, n);
        repeat (23) @(posedge clk);
        #1 div_done = 1'b0;
        @(negedge clk);
        chk("level_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("level_hs", 32'(n_hs - hs0), 32'd1);

        // overrun while in VALID
        drive_edge();
        out_ready = 1'b0;
        start(500, 12);
        wait_valid(1'b1, n);
        drive_edge();
        div_done = 1'b1;
        drive_edge();
        div_done = 1'b0;
        @(negedge clk);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(out_valid), 32'd1);
        chk("ovr_q", 32'(q_bcd), 32'h00500);
        drive_edge();
        overrun_clr = 1'b1;
        drive_edge();
        overrun_clr = 1'b0;
        @(negedge clk);
        chk("ovr_clr", 32'(overrun), 32'd0);
        drive_edge();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ovr_done", 32'(out_valid), 32'd0);

        // reset at step 8 of CONVERT
        drive_edge();
        start(9999, 1);
        @(posedge clk);
        #1 div_done = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bcd", 32'({q_bcd, r_bcd} != 0), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        drive_edge();
        rst = 1'b0;
        hs0 = n_hs;
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("abort_hs", 32'(n_hs - hs0), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        drive_edge();
        start(100, 0);
        wait_valid(1'b1, n);
        chk("post_rst_q", 32'(q_bcd), 32'h00100);
        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
